// File: rtl/tcp_port_scrub_pkg.sv
// Shared TCP port-table word layout and scrub request/completion types.
// Both the table owner and the scrubber import these so the valid bit and region field agree.
package tcp_port_scrub_pkg;

  localparam int N_REGIONS_BITS           = 4;
  localparam int TCP_IP_PORT_BITS         = 16;
  localparam int TCP_PORT_TABLE_ADDR_BITS = 10;
  localparam int TCP_PORT_TABLE_DATA_BITS = 1 + N_REGIONS_BITS;
  localparam int TCP_PORT_TABLE_VALID_BIT = TCP_PORT_TABLE_DATA_BITS - 1;

  typedef struct packed {
    logic [N_REGIONS_BITS-1:0] vfid;
  } tcp_scrub_req_t;

  typedef struct packed {
    logic [N_REGIONS_BITS-1:0]         vfid;
    logic [TCP_PORT_TABLE_ADDR_BITS:0] count;
  } tcp_scrub_done_t;

  // A table word belongs to a region only while its valid bit is set.
  function automatic logic tcp_pt_owned(input logic [TCP_PORT_TABLE_DATA_BITS-1:0] word,
                                        input logic [N_REGIONS_BITS-1:0]           vfid);
    return word[TCP_PORT_TABLE_VALID_BIT] && (word[N_REGIONS_BITS-1:0] == vfid);
  endfunction

endpackage

// File: rtl/tcp_port_scrub.sv
// Region-teardown sweep: locks port A of the TCP port table and invalidates every entry of one region.
// Define TCP_SCRUB_CLOSE_EN to issue one close-port handshake per invalidated entry.
module tcp_port_scrub
  import tcp_port_scrub_pkg::*;
#(
  parameter int PT_ADDR_BITS = TCP_PORT_TABLE_ADDR_BITS,
  parameter int PT_DATA_BITS = TCP_PORT_TABLE_DATA_BITS,
  parameter int RD_LAT       = 2
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        s_scrub_valid,
  output logic                        s_scrub_ready,
  input  logic [N_REGIONS_BITS-1:0]   s_scrub_vfid,
  output logic                        m_done_valid,
  output logic [N_REGIONS_BITS-1:0]   m_done_vfid,
  output logic [PT_ADDR_BITS:0]       m_done_count,
  output logic                        lock_req,
  input  logic                        lock_gnt,
  output logic [PT_ADDR_BITS-1:0]     tbl_addr,
  input  logic [PT_DATA_BITS-1:0]     tbl_rd_data,
  output logic                        tbl_we,
  output logic [PT_DATA_BITS-1:0]     tbl_wdata,
  output logic                        m_close_valid,
  input  logic                        m_close_ready,
  output logic [TCP_IP_PORT_BITS-1:0] m_close_port,
  output logic                        busy
);

  localparam int LAT_BITS = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOCK, ST_RD, ST_W1, ST_W2, ST_WR,
`ifdef TCP_SCRUB_CLOSE_EN
    ST_CLOSE,
`endif
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [PT_ADDR_BITS-1:0] idx_q, idx_d;
  logic [PT_ADDR_BITS:0] cnt_q, cnt_d;
  logic [LAT_BITS-1:0]   lat_q, lat_d;
  tcp_scrub_req_t        req_q, req_d;
  logic                  ready_q, busy_q, we_q, done_valid_q;
  tcp_scrub_done_t       done_q;

  logic                    hit_s;
  logic                    last_s;
  state_t                  adv_state_s;
  logic [PT_ADDR_BITS-1:0] adv_idx_s;

  assign hit_s       = tcp_pt_owned(tbl_rd_data, req_q.vfid);
  assign last_s      = &idx_q;
  assign adv_state_s = last_s ? ST_DONE : ST_RD;
  assign adv_idx_s   = last_s ? idx_q : idx_q + 1'b1;

  // Next-state logic; idx stops at the last entry instead of wrapping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (s_scrub_valid && ready_q) begin
          req_d.vfid = s_scrub_vfid;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = ST_LOCK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (lock_gnt) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_LOCK;
        end
      end
      ST_RD: begin
        lat_d   = '0;
        state_d = ST_W1;
      end
      ST_W1: begin
        if (lat_q == LAT_BITS'(RD_LAT - 2)) begin
          state_d = ST_W2;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_W2: begin
        if (hit_s) begin
          state_d = ST_WR;
        end else begin
          state_d = adv_state_s;
          idx_d   = adv_idx_s;
        end
      end
      ST_WR: begin
        cnt_d = cnt_q + 1'b1;
`ifdef TCP_SCRUB_CLOSE_EN
        state_d = ST_CLOSE;
`else
        state_d = adv_state_s;
        idx_d   = adv_idx_s;
`endif
      end
`ifdef TCP_SCRUB_CLOSE_EN
      ST_CLOSE: begin
        if (m_close_ready) begin
          state_d = adv_state_s;
          idx_d   = adv_idx_s;
        end else begin
          state_d = ST_CLOSE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and outputs are all registered from the next-state view.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
      req_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      done_valid_q <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      req_q        <= req_d;
      ready_q      <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      we_q         <= (state_d == ST_WR);
      done_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        done_q.vfid  <= req_d.vfid;
        done_q.count <= cnt_d;
      end else begin
        done_q <= '0;
      end
    end
  end

`ifdef TCP_SCRUB_CLOSE_EN
  logic                        close_valid_q;
  logic [TCP_IP_PORT_BITS-1:0] close_port_q;

  // Close request mirrors the CLOSE state and carries the freed index.
  always_ff @(posedge aclk) begin
    if (areset) begin
      close_valid_q <= 1'b0;
      close_port_q  <= '0;
    end else if (state_d == ST_CLOSE) begin
      close_valid_q <= 1'b1;
      close_port_q  <= TCP_IP_PORT_BITS'(idx_d);
    end else begin
      close_valid_q <= 1'b0;
      close_port_q  <= '0;
    end
  end

  assign m_close_valid = close_valid_q;
  assign m_close_port  = close_port_q;
`else
  logic unused_close_ready_s;
  assign unused_close_ready_s = m_close_ready;
  assign m_close_valid        = 1'b0;
  assign m_close_port         = '0;
`endif

  assign s_scrub_ready = ready_q;
  assign busy          = busy_q;
  assign lock_req      = busy_q;
  assign tbl_addr      = idx_q;
  assign tbl_we        = we_q;
  assign tbl_wdata     = '0;
  assign m_done_valid  = done_valid_q;
  assign m_done_vfid   = done_q.vfid;
  assign m_done_count  = done_q.count;

endmodule

// File: tb/tb_tcp_port_scrub.sv
// Directed scoreboard bench for tcp_port_scrub with a 2-cycle-latency port table model.
// Define TCP_SCRUB_CLOSE_EN for RTL and bench together to cover the close handshake.
module tb_tcp_port_scrub;
  import tcp_port_scrub_pkg::*;

  localparam int AW    = TCP_PORT_TABLE_ADDR_BITS;
  localparam int DW    = TCP_PORT_TABLE_DATA_BITS;
  localparam int NB    = N_REGIONS_BITS;
  localparam int NENT  = 1 << AW;
  localparam int SWEEP = 3 * NENT;
`ifdef TCP_SCRUB_CLOSE_EN
  localparam int HIT_EXTRA = 2;
`else
  localparam int HIT_EXTRA = 1;
`endif

  logic                        aclk = 1'b0;
  logic                        areset;
  logic                        s_scrub_valid;
  logic                        s_scrub_ready;
  logic [NB-1:0]               s_scrub_vfid;
  logic                        m_done_valid;
  logic [NB-1:0]               m_done_vfid;
  logic [AW:0]                 m_done_count;
  logic                        lock_req;
  logic                        lock_gnt;
  logic [AW-1:0]               tbl_addr;
  logic [DW-1:0]               tbl_rd_data;
  logic                        tbl_we;
  logic [DW-1:0]               tbl_wdata;
  logic                        m_close_valid;
  logic                        m_close_ready;
  logic [TCP_IP_PORT_BITS-1:0] m_close_port;
  logic                        busy;

  tcp_port_scrub dut (
    .aclk(aclk), .areset(areset),
    .s_scrub_valid(s_scrub_valid), .s_scrub_ready(s_scrub_ready), .s_scrub_vfid(s_scrub_vfid),
    .m_done_valid(m_done_valid), .m_done_vfid(m_done_vfid), .m_done_count(m_done_count),
    .lock_req(lock_req), .lock_gnt(lock_gnt),
    .tbl_addr(tbl_addr), .tbl_rd_data(tbl_rd_data), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata),
    .m_close_valid(m_close_valid), .m_close_ready(m_close_ready), .m_close_port(m_close_port),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Table model: port outputs captured mid-cycle, read data two edges after the address.
  logic [DW-1:0] mem      [NENT];
  logic [DW-1:0] init_mem [NENT];
  logic          load_mem;
  logic [AW-1:0] addr_n;
  logic          we_n;
  logic [DW-1:0] wdata_n, rd1, rd2;

  always @(negedge aclk) begin
    addr_n  <= tbl_addr;
    we_n    <= tbl_we;
    wdata_n <= tbl_wdata;
  end

  always @(posedge aclk) begin
    rd1 <= mem[addr_n];
    rd2 <= rd1;
    if (load_mem) begin
      for (int i = 0; i < NENT; i++) mem[i] <= init_mem[i];
    end else if (we_n) begin
      mem[addr_n] <= wdata_n;
    end
  end
  assign tbl_rd_data = rd2;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int              we_addr_q[$];
  int              close_q[$];
  int              done_cyc_q[$];
  logic [NB+AW:0]  done_val_q[$];
  int              exp_we[$];
  int              exp_done_cyc[$];
  logic [NB+AW:0]  exp_done_val[$];

  always @(negedge aclk) begin
    if (tbl_we === 1'b1) we_addr_q.push_back(int'(tbl_addr));
    if (m_close_valid === 1'b1 && m_close_ready === 1'b1) close_q.push_back(int'(m_close_port));
    if (m_done_valid === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_val_q.push_back({m_done_vfid, m_done_count});
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [NB+AW:0] dv(input int vf, input int c);
    return {NB'(vf), (AW+1)'(c)};
  endfunction

  function automatic logic [DW-1:0] ent(input logic v, input int vf);
    return {v, NB'(vf)};
  endfunction

  task automatic clear_init();
    for (int i = 0; i < NENT; i++) init_mem[i] = '0;
  endtask

  task automatic load_table();
    load_mem = 1'b1;
    @(negedge aclk);
    load_mem = 1'b0;
  endtask

  task automatic send(input int vf, output int acc);
    int n = 0;
    s_scrub_vfid  = NB'(vf);
    s_scrub_valid = 1'b1;
    while (s_scrub_ready !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("accept", s_scrub_ready, 1'b1);
    acc = cyc;
    @(negedge aclk);
    s_scrub_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (m_done_valid !== 1'b1 && n < bound) begin
      @(negedge aclk);
      n++;
    end
    chk("done_pulse", m_done_valid, 1'b1);
    @(negedge aclk);
    chk("done_one_cycle", m_done_valid, 1'b0);
    chk("lock_released", lock_req, 1'b0);
  endtask

  task automatic check_done();
    chk("done_events", done_val_q.size(), exp_done_val.size());
    while (done_val_q.size() > 0 && exp_done_val.size() > 0 && exp_done_cyc.size() > 0) begin
      chk("done_vfid_count", done_val_q.pop_front(), exp_done_val.pop_front());
      chk("done_cycle", done_cyc_q.pop_front(), exp_done_cyc.pop_front());
    end
    done_val_q.delete(); done_cyc_q.delete(); exp_done_val.delete(); exp_done_cyc.delete();
  endtask

  task automatic check_we();
`ifdef TCP_SCRUB_CLOSE_EN
    chk("close_events", close_q.size(), exp_we.size());
    for (int i = 0; i < close_q.size() && i < exp_we.size(); i++) chk("close_port", close_q[i], exp_we[i]);
`endif
    chk("we_events", we_addr_q.size(), exp_we.size());
    while (we_addr_q.size() > 0 && exp_we.size() > 0) chk("we_addr", we_addr_q.pop_front(), exp_we.pop_front());
    we_addr_q.delete(); exp_we.delete(); close_q.delete();
  endtask

  initial begin
    int acc, g, d1, bad, n;
    areset = 1'b1; s_scrub_valid = 1'b0; s_scrub_vfid = '0;
    lock_gnt = 1'b0; m_close_ready = 1'b1; load_mem = 1'b0;
    clear_init();
    repeat (3) @(negedge aclk);
    load_table();
    chk("reset_ctrl", {s_scrub_ready, busy, lock_req, tbl_we, m_done_valid, m_close_valid}, 6'b0);
    chk("reset_addr", tbl_addr, '0);
    chk("reset_done_data", {m_done_vfid, m_done_count, m_close_port}, '0);
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", s_scrub_ready, 1'b1);

    // Empty table, grant already present: no writes, fixed sweep length.
    lock_gnt = 1'b1;
    send(2, acc);
    exp_done_val.push_back(dv(2, 0)); exp_done_cyc.push_back(acc + 2 + SWEEP);
    wait_done(SWEEP + 100);
    check_done(); check_we();

    // Hits at 5 and the last index; foreign and invalid entries survive.
    init_mem[5] = ent(1'b1, 2); init_mem[1023] = ent(1'b1, 2);
    init_mem[6] = ent(1'b1, 3); init_mem[7]    = ent(1'b0, 2);
    load_table();
    send(2, acc);
    exp_we.push_back(5); exp_we.push_back(1023);
    exp_done_val.push_back(dv(2, 2)); exp_done_cyc.push_back(acc + 2 + SWEEP + 2 * HIT_EXTRA);
    wait_done(SWEEP + 100);
    check_done(); check_we();
    chk("t2_e5", mem[5], '0);
    chk("t2_e1023", mem[1023], '0);
    chk("t2_e6", mem[6], ent(1'b1, 3));
    chk("t2_e7", mem[7], ent(1'b0, 2));
`ifndef TCP_SCRUB_CLOSE_EN
    chk("close_tied_off", {m_close_valid, m_close_port}, '0);
`endif

    // Grant withheld for 50 cycles.
    lock_gnt = 1'b0;
    send(2, acc);
    bad = 0;
    repeat (50) begin
      @(negedge aclk);
      if (lock_req !== 1'b1 || busy !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== '0) bad++;
    end
    chk("t3_lock_wait", bad, 0);
    lock_gnt = 1'b1;
    g = cyc;
    exp_done_val.push_back(dv(2, 0)); exp_done_cyc.push_back(g + 1 + SWEEP);
    wait_done(SWEEP + 100);
    check_done(); check_we();

`ifdef TCP_SCRUB_CLOSE_EN
    // Close stalled at index 5 for 10 cycles.
    clear_init(); init_mem[5] = ent(1'b1, 2); init_mem[9] = ent(1'b1, 2);
    load_table();
    m_close_ready = 1'b0;
    send(2, acc);
    n = 0;
    while (m_close_valid !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("t4_close_valid", m_close_valid, 1'b1);
    chk("t4_close_port", m_close_port, 16'd5);
    bad = 0;
    repeat (10) begin
      @(negedge aclk);
      if (m_close_valid !== 1'b1 || m_close_port !== 16'd5 || tbl_addr !== 10'd5) bad++;
    end
    chk("t4_stall_hold", bad, 0);
    m_close_ready = 1'b1;
    @(negedge aclk);
    chk("t4_resume_idx", tbl_addr, 10'd6);
    chk("t4_close_drop", m_close_valid, 1'b0);
    exp_we.push_back(5); exp_we.push_back(9);
    exp_done_val.push_back(dv(2, 2)); exp_done_cyc.push_back(acc + 2 + SWEEP + 2 * HIT_EXTRA + 10);
    wait_done(SWEEP + 100);
    check_done(); check_we();
`endif

    // Reset at index 400 abandons the sweep silently.
    clear_init();
    init_mem[10] = ent(1'b1, 2); init_mem[200] = ent(1'b1, 2);
    init_mem[500] = ent(1'b1, 2); init_mem[6] = ent(1'b1, 3);
    load_table();
    send(2, acc);
    exp_we.push_back(10); exp_we.push_back(200);
    n = 0;
    while (tbl_addr !== 10'd400 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    chk("t5_reach_400", tbl_addr, 10'd400);
    areset = 1'b1;
    @(negedge aclk);
    chk("t5_reset_idle", {busy, lock_req, m_done_valid, tbl_we, m_close_valid, s_scrub_ready}, 6'b0);
    areset = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t5_ready_back", {s_scrub_ready, busy}, 2'b10);
    chk("t5_no_done", done_val_q.size(), 0);
    check_we();
    chk("t5_e10", mem[10], '0);
    chk("t5_e200", mem[200], '0);
    chk("t5_e500", mem[500], ent(1'b1, 2));

    // Second request raised mid-sweep waits for the first completion.
    send(2, acc);
    exp_we.push_back(500);
    exp_done_val.push_back(dv(2, 1)); exp_done_cyc.push_back(acc + 2 + SWEEP + HIT_EXTRA);
    repeat (20) @(negedge aclk);
    s_scrub_vfid = NB'(3); s_scrub_valid = 1'b1;
    bad = 0; n = 0;
    while (m_done_valid !== 1'b1 && n < SWEEP + 100) begin
      if (s_scrub_ready !== 1'b0) bad++;
      @(negedge aclk);
      n++;
    end
    chk("t6_ready_low", bad, 0);
    chk("t6_first_done", m_done_valid, 1'b1);
    d1 = cyc;
    @(negedge aclk);
    chk("t6_ready_idle", s_scrub_ready, 1'b1);
    exp_we.push_back(6);
    exp_done_val.push_back(dv(3, 1)); exp_done_cyc.push_back(d1 + 3 + SWEEP + HIT_EXTRA);
    @(negedge aclk);
    s_scrub_valid = 1'b0;
    chk("t6_second_started", busy, 1'b1);
    wait_done(SWEEP + 100);
    check_done(); check_we();
    chk("t6_e500", mem[500], '0);
    chk("t6_e6", mem[6], '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
